// File: rtl/product_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : product_bcd_converter
// Purpose  : Sequential binary-to-BCD converter (double-dabble, one bit per
//            clock) intended to sit between a multiplier product and a
//            decimal display stage. Valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
//
// Ports
//   clk        in   1          single clock, rising edge
//   reset      in   1          asynchronous, active-low reset
//   in_valid   in   1          binary value offered on bin
//   in_ready   out  1          converter idle and able to accept
//   bin        in   WIDTH      unsigned binary input
//   out_valid  out  1          bcd holds a completed conversion
//   out_ready  in   1          consumer takes the result
//   bcd        out  4*DIGITS   packed BCD, digit 0 (ones) in bits [3:0]
//   busy       out  1          conversion in progress
// ============================================================================
module product_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);

  // Counter must be able to hold the value WIDTH without wrapping.
  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [WIDTH-1:0]      r_sr;
  logic [4*DIGITS-1:0]   r_acc;
  logic [CW-1:0]         r_cnt;
  logic [4*DIGITS-1:0]   r_bcd;

  logic [4*DIGITS-1:0]   w_adj;
  logic [4*DIGITS-1:0]   w_acc_shift;
  logic                  w_last;
  logic                  w_accept;

  // --------------------------------------------------------------------------
  // Double-dabble step: add 3 to every digit >= 5, then shift the next binary
  // bit (MSB first) into the ones digit.
  // --------------------------------------------------------------------------
  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
    end
  end

  assign w_acc_shift = {w_adj[4*DIGITS-2:0], r_sr[WIDTH-1]};
  assign w_last      = (r_cnt == LAST);
  assign w_accept    = (r_state == S_IDLE) && in_valid;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: shift register, digit accumulator, step counter, result.
  // The result register is only written on the final step so that bcd stays
  // stable through a whole conversion and the following DONE phase.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr  <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_bcd <= '0;
    end else begin
      if (w_accept) begin
        r_sr  <= bin;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
        r_acc <= w_acc_shift;
        r_sr  <= {r_sr[WIDTH-2:0], 1'b0};
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_bcd <= w_acc_shift;
        end
      end
    end
  end

  assign bcd = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_product_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_product_bcd_converter
// Purpose  : Scoreboard bench for product_bcd_converter. Stimulus pushes the
//            hand-computed BCD result when a value is offered; an independent
//            monitor pops and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_product_bcd_converter;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     bin;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*DIGITS-1:0]  bcd;
  logic                 busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [4*DIGITS-1:0]  exp_q[$];
  int                   hs_t[$];

  product_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      hs_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_result: got bcd 0x%0h, expected no result", bcd);
      end else begin
        check("scoreboard_bcd", 32'(bcd), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("wait_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Offer one value, record its expected result, hold for the accepting edge.
  task automatic send(input logic [WIDTH-1:0] v, input logic [4*DIGITS-1:0] e);
    bin      = v;
    in_valid = 1'b1;
    wait_ready();
    exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (out_valid !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int bad;
    logic [WIDTH-1:0]    b2b_in [4];
    logic [4*DIGITS-1:0] b2b_ex [4];
    b2b_in = '{16'd9, 16'd10, 16'd99, 16'd100};
    b2b_ex = '{20'h00009, 20'h00010, 20'h00099, 20'h00100};

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin       = '0;

    // Reset state
    #12;
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_bcd",       32'(bcd),       32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Zero input, latency of WIDTH edges from acceptance to out_valid
    out_ready = 1'b1;
    send(16'h0000, 20'h00000);
    check("shift_busy",      32'(busy),      32'd1);
    check("shift_in_ready",  32'(in_ready),  32'd0);
    check("shift_out_valid", 32'(out_valid), 32'd0);
    wait_valid(k);
    check("latency_edges", 32'(k), 32'd16);
    wait_empty();
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Full-scale and 12345; bcd must hold the old result during SHIFT
    send(16'hFFFF, 20'h65535);
    wait_valid(k);
    wait_empty();
    send(16'h3039, 20'h12345);
    repeat (5) tick();
    check("bcd_stable_in_shift", 32'(bcd), 32'h65535);
    wait_valid(k);
    wait_empty();

    // Back-pressure: result held for 10 clocks, then taken
    out_ready = 1'b0;
    send(16'h0899, 20'h02201);
    wait_valid(k);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || bcd !== 20'h02201) bad++;
    end
    check("backpressure_hold_errors", 32'(bad), 32'd0);
    check("backpressure_bcd", 32'(bcd), 32'h02201);
    out_ready = 1'b1;
    tick();
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready",  32'(in_ready),  32'd1);
    check("release_drained",   32'(exp_q.size()), 32'd0);

    // Abort: reset at SHIFT cycle 7, result discarded
    send(16'h1234, 20'h04660);
    repeat (7) tick();
    reset = 1'b0;
    #1;
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_bcd",       32'(bcd),       32'd0);
    void'(exp_q.pop_back());
    repeat (2) tick();
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    check("abort_no_out_valid", 32'(bad), 32'd0);
    send(16'h0064, 20'h00100);
    wait_valid(k);
    wait_empty();

    // in_valid and bin changes during SHIFT are ignored
    send(16'h00FF, 20'h00255);
    repeat (3) tick();
    in_valid = 1'b1;
    bin      = 16'h0001;
    repeat (2) tick();
    in_valid = 1'b0;
    bin      = 16'hABCD;
    wait_valid(k);
    wait_empty();

    // Back-to-back with in_valid and out_ready held high
    hs_t.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bin = b2b_in[i];
      wait_ready();
      exp_q.push_back(b2b_ex[i]);
      tick();
    end
    in_valid = 1'b0;
    wait_empty();
    check("b2b_handshakes", 32'(hs_t.size()), 32'd4);
    if (hs_t.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
        check("b2b_spacing", 32'(hs_t[i] - hs_t[i-1]), 32'd18);
      end
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
